// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder: one DIGIT-bit slice per clock, LSB first, start/busy/done handshake
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] sum_next;

  always_comb begin
    slice = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  end

  // New slice enters at the MSB end so after N slices the first one lands at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_full
      always_comb sum_next = slice[DIGIT-1:0];
    end else begin : g_part
      always_comb sum_next = {slice[DIGIT-1:0], sum[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_carry_in;
  always_comb msb_carry_in = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ slice[DIGIT-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum   <= sum_next;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= slice[DIGIT];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            cout  <= slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= msb_carry_in ^ slice[DIGIT];
`endif
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
